gci_std_sync_fifo_th: RTL

Parametrised single-clock FIFO with run-time programmable almost-full/almost-empty thresholds, sticky overflow/underflow error flags and an optional registered first-word-fall-through output stage. Used as the general-purpose queue between display-pipeline stages (command, pixel and readback paths) wherever a producer needs early back-pressure and the consumer needs a timing-clean read port.

---
 rtl/gci_std_fifo_pkg.sv | 23 ++
 rtl/gci_std_sync_fifo_ram.sv | 39 +++
 rtl/gci_std_sync_fifo_th.sv | 129 ++++++++++++
 3 files changed

// File: rtl/gci_std_fifo_pkg.sv
// gci_std_fifo_pkg: shared helpers for the gci_std synchronous FIFO family.
// Pointer/count width derivation, threshold compare helpers and reset constants.
package gci_std_fifo_pkg;

  // Pointers carry one extra wrap bit so full and empty stay distinguishable
  function automatic int fifoPtrWidth(input int depthN);
    return depthN + 1;
  endfunction

  // Almost-full style compare: level reached or passed
  function automatic logic atOrAbove(input logic [31:0] level, input logic [31:0] threshold);
    return (level >= threshold);
  endfunction

  // Almost-empty style compare: level at or under the mark
  function automatic logic atOrBelow(input logic [31:0] level, input logic [31:0] threshold);
    return (level <= threshold);
  endfunction

  localparam logic RESET_ERR   = 1'b0;
  localparam logic RESET_VALID = 1'b0;

endpackage

// File: rtl/gci_std_sync_fifo_ram.sv
// gci_std_sync_fifo_ram: P_DEPTH x P_N dual-port storage, one write port.
// Read port is asynchronous by default; with GCI_STD_SYNC_FIFO_OUTREG_EN
// defined it becomes a registered, enabled read whose output register
// doubles as the FIFO output stage (reset to 0, held while not enabled).
module gci_std_sync_fifo_ram #(
  parameter int P_N       = 16,
  parameter int P_DEPTH   = 16,
  parameter int P_DEPTH_N = 4
) (
  input  logic                 iCLOCK,
`ifdef GCI_STD_SYNC_FIFO_OUTREG_EN
  input  logic                 inRESET,
  input  logic                 iRD_EN,
`endif
  input  logic                 iWR_EN,
  input  logic [P_DEPTH_N-1:0] iWR_ADDR,
  input  logic [P_N-1:0]       iWR_DATA,
  input  logic [P_DEPTH_N-1:0] iRD_ADDR,
  output logic [P_N-1:0]       oRD_DATA
);

  logic [P_N-1:0] mem [0:P_DEPTH-1];

  // Write port; contents are intentionally never reset
  always_ff @(posedge iCLOCK) begin
    if (iWR_EN) mem[iWR_ADDR] <= iWR_DATA;
  end

`ifdef GCI_STD_SYNC_FIFO_OUTREG_EN
  // Registered read: loads the head word when the top asks for it, else holds
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET)    oRD_DATA <= '0;
    else if (iRD_EN) oRD_DATA <= mem[iRD_ADDR];
  end
`else
  assign oRD_DATA = mem[iRD_ADDR];
`endif

endmodule

// File: rtl/gci_std_sync_fifo_th.sv
// gci_std_sync_fifo_th: single-clock FIFO with programmable almost-full /
// almost-empty thresholds and sticky overflow/underflow flags.
// Optional output stage: define GCI_STD_SYNC_FIFO_OUTREG_EN for a registered
// first-word-fall-through read port (2-edge write-to-read latency).
module gci_std_sync_fifo_th
  import gci_std_fifo_pkg::*;
#(
  parameter int P_N       = 16,
  parameter int P_DEPTH   = 16,
  parameter int P_DEPTH_N = 4
) (
  input  logic                 iCLOCK,
  input  logic                 inRESET,
  input  logic                 iREMOVE,
  input  logic [P_DEPTH_N:0]   iAF_THRESHOLD,
  input  logic [P_DEPTH_N:0]   iAE_THRESHOLD,
  input  logic                 iERR_CLEAR,
  output logic [P_DEPTH_N:0]   oCOUNT,
  input  logic                 iWR_EN,
  input  logic [P_N-1:0]       iWR_DATA,
  output logic                 oWR_FULL,
  output logic                 oWR_ALMOST_FULL,
  output logic                 oWR_OVERFLOW,
  input  logic                 iRD_EN,
  output logic [P_N-1:0]       oRD_DATA,
  output logic                 oRD_EMPTY,
  output logic                 oRD_ALMOST_EMPTY,
  output logic                 oRD_UNDERFLOW
);

  localparam int PW = fifoPtrWidth(P_DEPTH_N);

  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] memCount;
  logic [PW-1:0] count;
  logic          full;
  logic          empty;
  logic          wrAccept;
  logic          rdAccept;
  logic          wrCommit;
  logic          rdAdvance;
  logic          overflow;
  logic          underflow;

  assign memCount = wrPtr - rdPtr;

`ifdef GCI_STD_SYNC_FIFO_OUTREG_EN
  logic outValid;
  // The output register is one of the P_DEPTH slots, so it counts toward full
  assign count     = memCount + PW'(outValid);
  assign empty     = !outValid;
  // Refill the output register whenever it is free or being consumed
  assign rdAdvance = !iREMOVE && (memCount != '0) && (!outValid || rdAccept);

  // Output-register occupancy
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET)       outValid <= RESET_VALID;
    else if (iREMOVE)   outValid <= 1'b0;
    else if (rdAdvance) outValid <= 1'b1;
    else if (rdAccept)  outValid <= 1'b0;
  end
`else
  assign count     = memCount;
  assign empty     = (memCount == '0);
  assign rdAdvance = rdAccept && !iREMOVE;
`endif

  assign full     = (count == PW'(P_DEPTH));
  assign wrAccept = iWR_EN && !full;
  assign rdAccept = iRD_EN && !empty;
  assign wrCommit = wrAccept && !iREMOVE;

  // Pointer update; flush overrides any access in the same cycle
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else if (iREMOVE) begin
      wrPtr <= '0;
      rdPtr <= '0;
    end else begin
      if (wrCommit)  wrPtr <= wrPtr + PW'(1);
      if (rdAdvance) rdPtr <= rdPtr + PW'(1);
    end
  end

  // Sticky error flags; a fresh error beats a clear in the same cycle
  always_ff @(posedge iCLOCK or negedge inRESET) begin
    if (!inRESET) begin
      overflow  <= RESET_ERR;
      underflow <= RESET_ERR;
    end else if (iREMOVE) begin
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      if (iWR_EN && full)     overflow  <= 1'b1;
      else if (iERR_CLEAR)    overflow  <= 1'b0;
      if (iRD_EN && empty)    underflow <= 1'b1;
      else if (iERR_CLEAR)    underflow <= 1'b0;
    end
  end

  gci_std_sync_fifo_ram #(
    .P_N       (P_N),
    .P_DEPTH   (P_DEPTH),
    .P_DEPTH_N (P_DEPTH_N)
  ) ram (
    .iCLOCK   (iCLOCK),
`ifdef GCI_STD_SYNC_FIFO_OUTREG_EN
    .inRESET  (inRESET),
    .iRD_EN   (rdAdvance),
`endif
    .iWR_EN   (wrCommit),
    .iWR_ADDR (wrPtr[P_DEPTH_N-1:0]),
    .iWR_DATA (iWR_DATA),
    .iRD_ADDR (rdPtr[P_DEPTH_N-1:0]),
    .oRD_DATA (oRD_DATA)
  );

  assign oCOUNT           = count;
  assign oWR_FULL         = full;
  assign oRD_EMPTY        = empty;
  assign oWR_OVERFLOW     = overflow;
  assign oRD_UNDERFLOW    = underflow;
  assign oWR_ALMOST_FULL  = atOrAbove(32'(count), 32'(iAF_THRESHOLD));
  assign oRD_ALMOST_EMPTY = atOrBelow(32'(count), 32'(iAE_THRESHOLD));

endmodule
